// File: rtl/l2ctl_pkg.sv
// rtl/l2ctl_pkg.sv - shared types and constants for the L2 fill arbiter
//
// Purpose: controller state encoding, fill-target encoding, block geometry
// helpers used by l2_fill_arbiter.
// Ports: none (package).
package l2ctl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STORE = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef enum logic {
    TGT_I = 1'b0,
    TGT_D = 1'b1
  } tgt_e;

  // Byte-offset mask of a block of 'words' halfwords.
  function automatic int off_mask(input int words);
    return 2 * words - 1;
  endfunction

  // Counters must be able to hold 'words' itself (saturation value).
  function automatic int cnt_w(input int words);
    return $clog2(words) + 1;
  endfunction

  localparam int WORDS_DEF = 8;
  localparam int OFF_MASK  = off_mask(WORDS_DEF);
  localparam int CNT_W     = cnt_w(WORDS_DEF);

endpackage

// File: rtl/l2_fill_arbiter.sv
// rtl/l2_fill_arbiter.sv - single owner of the shared L2 port: stores and I/D block fills
//
// Purpose: grants one of {store, D-miss, I-miss} at a time (in that priority),
// performs the one-cycle write-through store, or issues WORDS pipelined reads
// and streams the returned halfwords into the target cache, flagging the last.
// Ports:
//   clk, rst            clock, async active-low reset
//   imiss/_addr         I-cache miss request and byte address
//   dmiss/_addr         D-cache load miss request and byte address
//   st_req/_addr/_data  write-through store request; st_ack pulses when written
//   busy                controller not idle
//   mem_*               L2 port (en/wr/addr/wdata out, rdata/valid in)
//   fill_*              cache write port; fill_last marks the tag/valid install
module l2_fill_arbiter
  import l2ctl_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = WORDS_DEF,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          imiss,
  input  logic [AW-1:0] imiss_addr,
  input  logic          dmiss,
  input  logic [AW-1:0] dmiss_addr,
  input  logic          st_req,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ack,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid,
  output logic          fill_we_i,
  output logic          fill_we_d,
  output logic [AW-1:0] fill_addr,
  output logic [DW-1:0] fill_data,
  output logic          fill_last
);

  localparam int            CW       = cnt_w(WORDS);
  localparam int            LW       = $clog2(MEM_LAT + 1);
  localparam logic [AW-1:0] BLK_MASK = AW'(off_mask(WORDS));
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);
  localparam logic [CW-1:0] FULL     = CW'(WORDS);
  localparam logic [LW-1:0] LAT_FULL = LW'(MEM_LAT);

  state_e        state_q, state_d;
  tgt_e          tgt_q, tgt_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] rcv_cnt_q, rcv_cnt_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;

  logic          st_ack_d, busy_d, mem_en_d, mem_wr_d;
  logic [AW-1:0] mem_addr_d, fill_addr_d;
  logic [DW-1:0] mem_wdata_d, fill_data_d;
  logic          fill_we_i_d, fill_we_d_d, fill_last_d;

  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] b,
                                               input logic [CW-1:0] idx);
    return b + (AW'(idx) << 1);
  endfunction

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    st_ack_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    fill_we_i_d = 1'b0;
    fill_we_d_d = 1'b0;
    fill_addr_d = '0;
    fill_data_d = '0;
    fill_last_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        issue_cnt_d = '0;
        rcv_cnt_d   = '0;
        lat_cnt_d   = '0;
        if (st_req) begin
          // The registered mem_* outputs double as the latched store request.
          state_d     = S_STORE;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = st_addr;
          mem_wdata_d = st_data;
          st_ack_d    = 1'b1;
        end else if (dmiss || imiss) begin
          tgt_d       = dmiss ? TGT_D : TGT_I;
          base_d      = (dmiss ? dmiss_addr : imiss_addr) & ~BLK_MASK;
          state_d     = S_ISSUE;
          // Word 0 is issued straight from the grant so reads start next cycle.
          mem_en_d    = 1'b1;
          mem_addr_d  = base_d;
          issue_cnt_d = CW'(1);
        end
      end
      S_STORE: state_d = S_IDLE;
      S_ISSUE: begin
        mem_en_d    = 1'b1;
        mem_addr_d  = word_addr(base_q, issue_cnt_q);
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: if (rcv_cnt_q == FULL) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_ISSUE || state_q == S_DRAIN) begin
      // No read can return before MEM_LAT cycles after the first issue, so
      // earlier mem_valid pulses are stale and must not consume a slot.
      if (lat_cnt_q != LAT_FULL) lat_cnt_d = lat_cnt_q + 1'b1;
      if (mem_valid && lat_cnt_q == LAT_FULL && rcv_cnt_q != FULL) begin
        fill_we_i_d = (tgt_q == TGT_I);
        fill_we_d_d = (tgt_q == TGT_D);
        fill_data_d = mem_rdata;
        fill_last_d = (rcv_cnt_q == LAST_IDX);
        // Bit 0 of the block-aligned address carries the valid-bit install.
        fill_addr_d = word_addr(base_q, rcv_cnt_q) | AW'(fill_last_d);
        rcv_cnt_d   = rcv_cnt_q + 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tgt_q       <= TGT_I;
      base_q      <= '0;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      st_ack      <= 1'b0;
      busy        <= 1'b0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      fill_we_i   <= 1'b0;
      fill_we_d   <= 1'b0;
      fill_addr   <= '0;
      fill_data   <= '0;
      fill_last   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      st_ack      <= st_ack_d;
      busy        <= busy_d;
      mem_en      <= mem_en_d;
      mem_wr      <= mem_wr_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      fill_we_i   <= fill_we_i_d;
      fill_we_d   <= fill_we_d_d;
      fill_addr   <= fill_addr_d;
      fill_data   <= fill_data_d;
      fill_last   <= fill_last_d;
    end
  end

endmodule

// File: tb/tb_l2_fill_arbiter.sv
// tb/tb_l2_fill_arbiter.sv - scoreboard bench for l2_fill_arbiter (MEM_LAT 4 and 6 builds)
module tb_l2_fill_arbiter;
  import l2ctl_pkg::*;

  localparam int LAT  = 4;
  localparam int LAT6 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        imiss, dmiss, st_req, st_ack, busy, mem_en, mem_wr, mem_valid;
  logic [15:0] imiss_addr, dmiss_addr, st_addr, st_data, mem_addr, mem_wdata, mem_rdata;
  logic        fill_we_i, fill_we_d, fill_last;
  logic [15:0] fill_addr, fill_data;

  logic        imiss6, zero6, st_ack6, busy6, mem_en6, mem_wr6, mem_valid6;
  logic [15:0] imiss_addr6, zaddr6, mem_addr6, mem_wdata6, mem_rdata6;
  logic        fill_we_i6, fill_we_d6, fill_last6;
  logic [15:0] fill_addr6, fill_data6;

  l2_fill_arbiter #(.MEM_LAT(LAT), .WORDS(8), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst), .imiss(imiss), .imiss_addr(imiss_addr),
    .dmiss(dmiss), .dmiss_addr(dmiss_addr), .st_req(st_req), .st_addr(st_addr),
    .st_data(st_data), .st_ack(st_ack), .busy(busy), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .fill_addr(fill_addr), .fill_data(fill_data), .fill_last(fill_last));

  l2_fill_arbiter #(.MEM_LAT(LAT6), .WORDS(8), .AW(16), .DW(16)) dut6 (
    .clk(clk), .rst(rst), .imiss(imiss6), .imiss_addr(imiss_addr6),
    .dmiss(zero6), .dmiss_addr(zaddr6), .st_req(zero6), .st_addr(zaddr6),
    .st_data(zaddr6), .st_ack(st_ack6), .busy(busy6), .mem_en(mem_en6), .mem_wr(mem_wr6),
    .mem_addr(mem_addr6), .mem_wdata(mem_wdata6), .mem_rdata(mem_rdata6),
    .mem_valid(mem_valid6), .fill_we_i(fill_we_i6), .fill_we_d(fill_we_d6),
    .fill_addr(fill_addr6), .fill_data(fill_data6), .fill_last(fill_last6));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata; } mem_exp_t;
  typedef struct { int cyc; logic we_i; logic we_d; logic [15:0] addr; logic [15:0] data; logic last; } fill_exp_t;
  typedef struct { int due; logic [15:0] a; } rd_t;

  mem_exp_t  mq[$];
  fill_exp_t fq[$], fq6[$];
  rd_t       pq[$], pq6[$];
  int        spur6 = -1;

  // Expected traffic for a miss granted at cycle g: the L2 model returns word[a]=a.
  task automatic expect_miss(input int g, input bit is_d, input logic [15:0] a,
                             input int lat, input bit six);
    logic [15:0] base, wa;
    fill_exp_t   fe;
    base = a & ~16'(OFF_MASK);
    for (int k = 0; k < 8; k++) begin
      wa = base + 16'(2 * k);
      if (!six) mq.push_back('{cyc: g + 1 + k, wr: 1'b0, addr: wa, wdata: 16'h0});
      fe = '{cyc: g + 2 + lat + k, we_i: !is_d, we_d: is_d,
             addr: wa | 16'(k == 7), data: wa, last: (k == 7)};
      if (six) fq6.push_back(fe);
      else     fq.push_back(fe);
    end
  endtask

  // L2 models: a read issued in cycle c returns in cycle c+latency.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en && !mem_wr) pq.push_back('{due: cyc + LAT, a: mem_addr});
      if (pq.size() > 0 && pq[0].due == cyc) begin
        mem_valid = 1'b1;
        mem_rdata = pq[0].a;
        void'(pq.pop_front());
      end else begin
        mem_valid = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  initial begin
    mem_valid6 = 1'b0;
    mem_rdata6 = '0;
    forever begin
      @(negedge clk);
      if (mem_en6 && !mem_wr6) pq6.push_back('{due: cyc + LAT6, a: mem_addr6});
      if (pq6.size() > 0 && pq6[0].due == cyc) begin
        mem_valid6 = 1'b1;
        mem_rdata6 = pq6[0].a;
        void'(pq6.pop_front());
      end else if (spur6 == cyc) begin
        mem_valid6 = 1'b1;
        mem_rdata6 = 16'hDEAD;
      end else begin
        mem_valid6 = 1'b0;
        mem_rdata6 = '0;
      end
    end
  end

  // Monitors: every L2 access and cache write must match the head of its queue.
  mem_exp_t  me;
  fill_exp_t fe_m, fe6;
  always @(negedge clk) begin
    if (mem_en) begin
      if (mq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL mem_unexpected: got addr %h wr %b want no access (cycle %0d)", mem_addr, mem_wr, cyc);
      end else begin
        me = mq.pop_front();
        chk("mem_cycle", 32'(cyc), 32'(me.cyc));
        chk("mem_wr", 32'(mem_wr), 32'(me.wr));
        chk("mem_addr", 32'(mem_addr), 32'(me.addr));
        if (me.wr) chk("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
        chk("st_ack", 32'(st_ack), 32'(me.wr));
      end
    end else if (st_ack) begin
      n_cmp++; n_bad++;
      $display("FAIL st_ack_unexpected: got 1 want 0 (cycle %0d)", cyc);
    end
    if (fill_we_i || fill_we_d) begin
      if (fq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL fill_unexpected: got addr %h data %h want no write (cycle %0d)", fill_addr, fill_data, cyc);
      end else begin
        fe_m = fq.pop_front();
        chk("fill_cycle", 32'(cyc), 32'(fe_m.cyc));
        chk("fill_we", 32'({fill_we_i, fill_we_d}), 32'({fe_m.we_i, fe_m.we_d}));
        chk("fill_addr", 32'(fill_addr), 32'(fe_m.addr));
        chk("fill_data", 32'(fill_data), 32'(fe_m.data));
        chk("fill_last", 32'(fill_last), 32'(fe_m.last));
      end
    end else if (fill_last) begin
      n_cmp++; n_bad++;
      $display("FAIL fill_last_unexpected: got 1 want 0 (cycle %0d)", cyc);
    end
  end

  always @(negedge clk) begin
    if (fill_we_i6 || fill_we_d6) begin
      if (fq6.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL fill6_unexpected: got addr %h data %h want no write (cycle %0d)", fill_addr6, fill_data6, cyc);
      end else begin
        fe6 = fq6.pop_front();
        chk("fill6_cycle", 32'(cyc), 32'(fe6.cyc));
        chk("fill6_we", 32'({fill_we_i6, fill_we_d6}), 32'({fe6.we_i, fe6.we_d}));
        chk("fill6_addr", 32'(fill_addr6), 32'(fe6.addr));
        chk("fill6_data", 32'(fill_data6), 32'(fe6.data));
        chk("fill6_last", 32'(fill_last6), 32'(fe6.last));
      end
    end
  end

  int g;

  initial begin
    rst = 1'b0;
    imiss = 0; dmiss = 0; st_req = 0;
    imiss_addr = '0; dmiss_addr = '0; st_addr = '0; st_data = '0;
    imiss6 = 0; zero6 = 0; imiss_addr6 = '0; zaddr6 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ctl", 32'({st_ack, busy, mem_en, mem_wr, fill_we_i, fill_we_d, fill_last}), 32'h0);
    chk("reset_addr", {mem_addr, fill_addr}, 32'h0);
    chk("reset_data", {mem_wdata, fill_data}, 32'h0);
    chk("reset_busy6", 32'(busy6), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // I-miss at 0x1236: issues 1..8, fills 6..13, busy 1..14
    g = cyc;
    imiss = 1; imiss_addr = 16'h1236;
    expect_miss(g, 1'b0, 16'h1236, LAT, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 3) begin imiss = 0; imiss_addr = 16'hFFFF; end
      chk("busy_imiss", 32'(busy), 32'(i <= 14));
    end
    repeat (2) @(negedge clk);

    // I and D together: D first, then I right after
    g = cyc;
    imiss = 1; imiss_addr = 16'h0040;
    dmiss = 1; dmiss_addr = 16'h4008;
    expect_miss(g, 1'b1, 16'h4008, LAT, 1'b0);
    expect_miss(g + 15, 1'b0, 16'h0040, LAT, 1'b0);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      if (i == 2)  dmiss = 0;
      if (i == 17) imiss = 0;
      if (i == 15) chk("busy_between", 32'(busy), 32'h0);
    end
    chk("busy_after_id", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);

    // Store beats D-miss; D-fill issues from cycle 3
    g = cyc;
    st_req = 1; st_addr = 16'h0100; st_data = 16'hBEEF;
    dmiss = 1; dmiss_addr = 16'h2222;
    mq.push_back('{cyc: g + 1, wr: 1'b1, addr: 16'h0100, wdata: 16'hBEEF});
    expect_miss(g + 2, 1'b1, 16'h2222, LAT, 1'b0);
    @(negedge clk);
    st_req = 0; st_addr = 16'h5555; st_data = 16'h0;
    chk("busy_store", 32'(busy), 32'h1);
    @(negedge clk);
    chk("busy_after_store", 32'(busy), 32'h0);
    for (int i = 3; i <= 18; i++) begin
      @(negedge clk);
      if (i == 4) dmiss = 0;
    end
    chk("busy_after_sd", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);

    // Reset at cycle 7 of a fill: only issues 1..7 and fills 6..7 ever appear
    g = cyc;
    imiss = 1; imiss_addr = 16'h3000;
    for (int k = 0; k < 7; k++)
      mq.push_back('{cyc: g + 1 + k, wr: 1'b0, addr: 16'h3000 + 16'(2 * k), wdata: 16'h0});
    fq.push_back('{cyc: g + 6, we_i: 1'b1, we_d: 1'b0, addr: 16'h3000, data: 16'h3000, last: 1'b0});
    fq.push_back('{cyc: g + 7, we_i: 1'b1, we_d: 1'b0, addr: 16'h3002, data: 16'h3002, last: 1'b0});
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ctl", 32'({st_ack, busy, mem_en, mem_wr, fill_we_i, fill_we_d, fill_last}), 32'h0);
    chk("midrst_addr", {mem_addr, fill_addr}, 32'h0);
    chk("midrst_data", {mem_wdata, fill_data}, 32'h0);
    imiss = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("busy_after_rst", 32'(busy), 32'h0);

    // MEM_LAT=6 build: spurious valid in IDLE, then a 17-cycle miss
    spur6 = cyc + 1;
    repeat (3) @(negedge clk);
    g = cyc;
    imiss6 = 1; imiss_addr6 = 16'h0A5C;
    expect_miss(g, 1'b0, 16'h0A5C, LAT6, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 2) imiss6 = 0;
      chk("busy6", 32'(busy6), 32'(i <= 16));
    end
    repeat (3) @(negedge clk);

    chk("mem_queue_drained", 32'(mq.size()), 32'h0);
    chk("fill_queue_drained", 32'(fq.size()), 32'h0);
    chk("fill6_queue_drained", 32'(fq6.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_fill_arbiter.md
# l2_fill_arbiter

Sequencer and arbiter for the shared, pipelined L2 memory behind the split I/D caches. Accepts I-cache misses, D-cache load misses and CPU write-through stores, grants one at a time, and for a miss streams an 8-halfword block from L2 into the target cache. On the final word it installs the tag and valid bit. It replaces ad-hoc L2 enable/write muxing in the cache wrapper with one owner of the L2 port.

## Interface
- MEM_LAT, 4, L2 read latency in cycles from `mem_en` to `mem_valid`
- WORDS, 8, halfwords per block (power of 2)
- AW, 16, address width
- DW, 16, data width
---
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-low (0 = reset)
- imiss  in  1  I-cache miss pending
- imiss_addr  in  AW  I-cache miss byte address
- dmiss  in  1  D-cache load miss pending
- dmiss_addr  in  AW  D-cache miss byte address
- st_req  in  1  CPU store write-through request
- st_addr  in  AW  store address
- st_data  in  DW  store data
- st_ack  out  1  one-cycle pulse: store written to L2
- busy  out  1  controller not idle; pipeline stalls on it
- mem_en  out  1  L2 enable
- mem_wr  out  1  L2 write
- mem_addr  out  AW  L2 address
- mem_wdata  out  DW  L2 write data
- mem_rdata  in  DW  L2 read data
- mem_valid  in  1  L2 read data valid
- fill_we_i  out  1  write `fill_data` into I-cache
- fill_we_d  out  1  write `fill_data` into D-cache
- fill_addr  out  AW  cache write address; bit 0 = valid-bit install
- fill_data  out  DW  cache write data
- fill_last  out  1  final word of block; cache installs tag/valid

## Operation
- States: IDLE, STORE, ISSUE, DRAIN, DONE. `busy` = (state != IDLE).
- IDLE grant priority, evaluated each cycle: `st_req` > `dmiss` > `imiss`.
- On a grant, latch the request address, data and target (I/D). Later changes on request inputs are ignored until IDLE.
- STORE:
  - one cycle; `mem_en=1`, `mem_wr=1`, `mem_addr=st_addr`, `mem_wdata=st_data`, `st_ack=1`
  - next state IDLE
  - no cache write; stores are write-no-allocate, and hit update is the D-cache's job
- Miss block base = `miss_addr & ~(2*WORDS-1)`.
- ISSUE:
  - each cycle, `mem_en=1`, `mem_wr=0`, `mem_addr = base + 2*issue_cnt`
  - `issue_cnt` runs 0..WORDS-1
  - after the last issue, go to DRAIN
- Receive (ISSUE and DRAIN):
  - each `mem_valid` registers `fill_data=mem_rdata`, `fill_addr = base + 2*rcv_cnt`, and pulses the target `fill_we_*` the next cycle
  - `rcv_cnt` increments
  - on word WORDS-1: `fill_last=1` and `fill_addr[0]=1`; otherwise `fill_addr[0]=0`
- DRAIN goes to DONE in the cycle after the last fill write.
- DONE: one cycle, outputs idle; next state IDLE. The cache re-evaluates its miss with the block installed.
- Boundary and error handling:
  - `mem_valid` outside ISSUE/DRAIN, or after `rcv_cnt` reaches WORDS, is ignored; counters saturate
  - a requester dropping its miss mid-fill does not abort the fill
  - requests arriving while busy wait; none are queued beyond the live request lines
  - reset mid-fill: immediate return to IDLE, counters cleared, partial block never gets `fill_last`
- Reset values: every output 0, state IDLE, counters 0.

## Timing
- Miss seen in IDLE at cycle 0:
  - issues on cycles 1..WORDS
  - returns on cycles 1+MEM_LAT..WORDS+MEM_LAT
  - fill writes on cycles 2+MEM_LAT..WORDS+MEM_LAT+1, with `fill_last` on the last
  - DONE at WORDS+MEM_LAT+2; `busy` low the following cycle
- Defaults: `busy` high on cycles 1..14; 15-cycle miss turnaround.
- Store seen at cycle 0: L2 write and `st_ack` at cycle 1; `busy` high cycle 1 only.
- All outputs are registered, with no combinational input-to-output path.

## Structure
- Package `l2ctl_pkg`:
  - state enum
  - `OFF_MASK = 2*WORDS-1`
  - counter width `$clog2(WORDS)+1`
  - target encoding (TGT_I, TGT_D)
- Flat module. No sub-module is needed; the issue and receive counters are inline.

## Test plan
- `imiss=1`, `imiss_addr=0x1236`, L2 model with word[a]=a:
  - `mem_addr` = 0x1230..0x123E on cycles 1..8
  - `fill_we_i` with `fill_data` = 0x1230..0x123E on cycles 6..13
  - `fill_last` and `fill_addr=0x123F` at cycle 13; `busy` low at cycle 15
- `imiss` and `dmiss` (0x4008) both rise at cycle 0: the D-fill runs first with `fill_we_d` only; the I-fill starts immediately after DONE.
- `st_req`, `st_addr=0x0100`, `st_data=0xBEEF`, plus `dmiss` at cycle 0:
  - cycle 1: `mem_wr=1`, `mem_addr=0x0100`, `mem_wdata=0xBEEF`, `st_ack=1`
  - D-fill issues from cycle 3
- `rst=0` at cycle 7 of a fill:
  - all outputs 0 asynchronously, no `fill_last`
  - stray `mem_valid` after release is ignored and causes no `fill_we_*`
- MEM_LAT=6 build with a spurious `mem_valid` in IDLE: no fill write; the miss still completes in exactly 17 cycles.
